// File: rtl/game_mode_ctrl.sv
// rtl/game_mode_ctrl.sv - key debounce, IDLE/PLAY/PAUSE/OVER mode FSM, lives and pixel source select
// Optional feature macro: PAUSE_DIM_EN (halve each RGB565 field of game_rgb while paused)
module game_mode_ctrl #(
    parameter int NUM_KEYS         = 4,
    parameter int DEBOUNCE_CYCLES  = 500000,
    parameter int RGB_W            = 16,
    parameter int LIVES            = 3,
    parameter int OVER_HOLD_FRAMES = 120
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_KEYS-1:0]          key_in,
    input  logic                         frame_tick,
    input  logic                         lose,
    input  logic                         win,
    input  logic [RGB_W-1:0]             start_rgb,
    input  logic [RGB_W-1:0]             game_rgb,
    input  logic [RGB_W-1:0]             over_rgb,
    output logic [NUM_KEYS-1:0]          key_flag,
    output logic [NUM_KEYS-1:0]          game_key,
    output logic                         game_en,
    output logic                         game_rst,
    output logic                         serve,
    output logic [$clog2(LIVES+1)-1:0]   lives,
    output logic                         won,
    output logic [1:0]                   mode,
    output logic [RGB_W-1:0]             rgb_out,
    output logic [NUM_KEYS-1:0]          key_level
);

    localparam int LW     = $clog2(LIVES + 1);
    localparam int CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HOLD_W = $clog2(OVER_HOLD_FRAMES + 1);

    localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0]   HOLD_LAST  = HOLD_W'(OVER_HOLD_FRAMES - 1);
    localparam logic [LW-1:0]       LIVES_INIT = LW'(LIVES);
    localparam logic [LW-1:0]       LIVES_ONE  = LW'(1);
    localparam logic [NUM_KEYS-1:0] FWD_MASK   = ~(NUM_KEYS'(1));

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2,
        OVER  = 2'd3
    } mode_e;

    logic [NUM_KEYS-1:0] sync1_q, sync2_q;
    logic [NUM_KEYS-1:0] level_q, key_flag_q;
    logic [CNT_W-1:0]    cnt_q [NUM_KEYS];

    mode_e               mode_q, mode_d;
    logic [LW-1:0]       lives_q, lives_d;
    logic                won_q, won_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                game_rst_q, game_rst_d;
    logic                serve_q, serve_d;

    // Keys idle high, so the synchronisers reset to the released level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= '1;
            sync2_q    <= '1;
            level_q    <= '0;
            key_flag_q <= '0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= key_in;
            sync2_q <= sync1_q;
            for (int i = 0; i < NUM_KEYS; i++) begin
                key_flag_q[i] <= 1'b0;
                if (~sync2_q[i] == level_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    cnt_q[i]      <= '0;
                    level_q[i]    <= ~level_q[i];
                    key_flag_q[i] <= ~level_q[i];
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q     <= IDLE;
            lives_q    <= '0;
            won_q      <= 1'b0;
            hold_q     <= '0;
            game_rst_q <= 1'b0;
            serve_q    <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            lives_q    <= lives_d;
            won_q      <= won_d;
            hold_q     <= hold_d;
            game_rst_q <= game_rst_d;
            serve_q    <= serve_d;
        end
    end

    always_comb begin
        mode_d     = mode_q;
        lives_d    = lives_q;
        won_d      = won_q;
        hold_d     = hold_q;
        game_rst_d = 1'b0;
        serve_d    = 1'b0;
        case (mode_q)
            IDLE: begin
                if (key_flag_q[0]) begin
                    mode_d     = PLAY;
                    lives_d    = LIVES_INIT;
                    won_d      = 1'b0;
                    game_rst_d = 1'b1;
                end
            end
            PLAY: begin
                // lose outranks win, which outranks the pause key
                if (lose) begin
                    if (lives_q <= LIVES_ONE) begin
                        lives_d = '0;
                        won_d   = 1'b0;
                        hold_d  = '0;
                        mode_d  = OVER;
                    end else begin
                        lives_d = lives_q - 1'b1;
                        serve_d = 1'b1;
                    end
                end else if (win) begin
                    won_d  = 1'b1;
                    hold_d = '0;
                    mode_d = OVER;
                end else if (key_flag_q[0]) begin
                    mode_d = PAUSE;
                end
            end
            PAUSE: begin
                if (key_flag_q[0]) begin
                    mode_d = PLAY;
                end
            end
            OVER: begin
                if (frame_tick) begin
                    if (hold_q == HOLD_LAST) begin
                        hold_d = '0;
                        mode_d = IDLE;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end
            default: mode_d = IDLE;
        endcase
    end

    // Pixel select stays combinational so it lines up with the incoming pixel.
    always_comb begin
        rgb_out = start_rgb;
        case (mode_q)
            IDLE:  rgb_out = start_rgb;
            PLAY:  rgb_out = game_rgb;
`ifdef PAUSE_DIM_EN
            PAUSE: rgb_out = {1'b0, game_rgb[15:12], 1'b0, game_rgb[10:6], 1'b0, game_rgb[4:1]};
`else
            PAUSE: rgb_out = game_rgb;
`endif
            OVER:  rgb_out = over_rgb;
            default: rgb_out = start_rgb;
        endcase
    end

    assign game_en   = (mode_q == PLAY);
    assign game_key  = game_en ? (key_flag_q & FWD_MASK) : '0;
    assign key_flag  = key_flag_q;
    assign key_level = level_q;
    assign game_rst  = game_rst_q;
    assign serve     = serve_q;
    assign lives     = lives_q;
    assign won       = won_q;
    assign mode      = mode_q;

endmodule

// File: tb/tb_game_mode_ctrl.sv
// tb/tb_game_mode_ctrl.sv - directed and random checks of game_mode_ctrl against a behavioural model
module tb_game_mode_ctrl;

    localparam int NK   = 4;
    localparam int DB   = 4;
    localparam int LV   = 3;
    localparam int HOLD = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [NK-1:0] key_in;
    logic          frame_tick, lose, win;
    logic [15:0]   start_rgb, game_rgb, over_rgb;
    logic [NK-1:0] key_flag, game_key, key_level;
    logic          game_en, game_rst, serve, won;
    logic [1:0]    lives;
    logic [1:0]    mode;
    logic [15:0]   rgb_out;

    game_mode_ctrl #(
        .NUM_KEYS(NK), .DEBOUNCE_CYCLES(DB), .RGB_W(16), .LIVES(LV), .OVER_HOLD_FRAMES(HOLD)
    ) dut (
        .clk(clk), .reset(reset), .key_in(key_in), .frame_tick(frame_tick),
        .lose(lose), .win(win), .start_rgb(start_rgb), .game_rgb(game_rgb),
        .over_rgb(over_rgb), .key_flag(key_flag), .game_key(game_key),
        .game_en(game_en), .game_rst(game_rst), .serve(serve), .lives(lives),
        .won(won), .mode(mode), .rgb_out(rgb_out), .key_level(key_level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: modes as plain ints, debounce as "DB consecutive disagreeing samples".
    int            m_mode, m_lives, m_ticks;
    bit            m_won, m_rst, m_serve;
    bit [NK-1:0]   m_level, m_flag;
    bit [NK-1:0]   raw_d1, raw_d2;
    int            run [NK];

    int rst_cnt, serve_cnt, gk_cnt;
    int flag_cnt [NK];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit [NK-1:0] f_now;
        f_now = m_flag;
        if (reset) begin
            m_mode = 0; m_lives = 0; m_ticks = 0; m_won = 0; m_rst = 0; m_serve = 0;
            m_level = '0; m_flag = '0; raw_d1 = '1; raw_d2 = '1;
            for (int k = 0; k < NK; k++) run[k] = 0;
            return;
        end
        m_rst = 0;
        m_serve = 0;
        case (m_mode)
            0: if (f_now[0]) begin m_mode = 1; m_lives = LV; m_won = 0; m_rst = 1; end
            1: begin
                if (lose) begin
                    if (m_lives <= 1) begin m_lives = 0; m_won = 0; m_mode = 3; m_ticks = 0; end
                    else begin m_lives = m_lives - 1; m_serve = 1; end
                end else if (win) begin
                    m_won = 1; m_mode = 3; m_ticks = 0;
                end else if (f_now[0]) begin
                    m_mode = 2;
                end
            end
            2: if (f_now[0]) m_mode = 1;
            default: if (frame_tick) begin
                m_ticks = m_ticks + 1;
                if (m_ticks == HOLD) m_mode = 0;
            end
        endcase
        for (int k = 0; k < NK; k++) begin
            bit pressed_now;
            pressed_now = !raw_d2[k];
            m_flag[k] = 0;
            if (pressed_now != m_level[k]) begin
                run[k] = run[k] + 1;
                if (run[k] == DB) begin
                    m_level[k] = pressed_now;
                    m_flag[k]  = pressed_now;
                    run[k]     = 0;
                end
            end else begin
                run[k] = 0;
            end
        end
        raw_d2 = raw_d1;
        raw_d1 = key_in;
    endtask

    task automatic compare();
        int r, g, b;
        logic [15:0] e_rgb;
        r = game_rgb / 2048;
        g = (game_rgb / 32) % 64;
        b = game_rgb % 32;
        case (m_mode)
            0: e_rgb = start_rgb;
            1: e_rgb = game_rgb;
`ifdef PAUSE_DIM_EN
            2: e_rgb = 16'((r / 2) * 2048 + (g / 2) * 32 + (b / 2));
`else
            2: e_rgb = game_rgb;
`endif
            default: e_rgb = over_rgb;
        endcase
        chk("mode", mode, m_mode);
        chk("lives", lives, m_lives);
        chk("won", won, m_won);
        chk("game_rst", game_rst, m_rst);
        chk("serve", serve, m_serve);
        chk("game_en", game_en, m_mode == 1);
        chk("key_level", key_level, m_level);
        chk("key_flag", key_flag, m_flag);
        chk("game_key", game_key, (m_mode == 1) ? (m_flag & 4'b1110) : 4'b0000);
        chk("rgb_out", rgb_out, e_rgb);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
        rst_cnt   += int'(game_rst);
        serve_cnt += int'(serve);
        gk_cnt    += int'(|game_key);
        for (int k = 0; k < NK; k++) flag_cnt[k] += int'(key_flag[k]);
    endtask

    task automatic clear_counts();
        rst_cnt = 0; serve_cnt = 0; gk_cnt = 0;
        for (int k = 0; k < NK; k++) flag_cnt[k] = 0;
    endtask

    task automatic press(input int k);
        key_in[k] = 1'b0;
        repeat (DB + 4) cyc();
        key_in[k] = 1'b1;
        repeat (DB + 4) cyc();
    endtask

    task automatic frame_pulse();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        cyc();
    endtask

    initial begin
        int first_flag;
        reset = 1'b1; key_in = '1; frame_tick = 0; lose = 0; win = 0;
        start_rgb = 16'h001F; game_rgb = 16'hF800; over_rgb = 16'h07E0;
        clear_counts();
        repeat (3) cyc();
        reset = 1'b0;
        cyc();
        chk("reset_mode", mode, 0);
        chk("reset_lives", lives, 0);
        chk("reset_level", key_level, 0);
        chk("reset_rgb", rgb_out, 16'h001F);

        // 3-cycle glitch must be filtered out
        key_in[1] = 1'b0;
        repeat (3) cyc();
        key_in[1] = 1'b1;
        repeat (10) cyc();
        chk("glitch_flags", flag_cnt[1], 0);

        // held press: one pulse DB+2 cycles after the edge
        first_flag = -1;
        key_in[1] = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            cyc();
            if (key_flag[1] && first_flag < 0) first_flag = n;
        end
        chk("flag_latency", first_flag, 6);
        chk("flag_count", flag_cnt[1], 1);
        chk("level_held", key_level[1], 1);
        key_in[1] = 1'b1;
        repeat (10) cyc();
        chk("level_released", key_level[1], 0);
        chk("flag_count_rel", flag_cnt[1], 1);

        // start a game
        clear_counts();
        press(0);
        chk("start_mode", mode, 1);
        chk("start_lives", lives, 3);
        chk("start_rst_pulses", rst_cnt, 1);
        chk("play_rgb", rgb_out, 16'hF800);

        // lose all lives
        clear_counts();
        lose = 1; cyc(); lose = 0; chk("lives_after1", lives, 2); cyc();
        lose = 1; cyc(); lose = 0; chk("lives_after2", lives, 1); cyc();
        lose = 1; cyc(); lose = 0; chk("lives_after3", lives, 0); cyc();
        chk("over_mode", mode, 3);
        chk("serve_pulses", serve_cnt, 2);
        chk("over_won", won, 0);
        chk("over_rgb", rgb_out, 16'h07E0);
        frame_pulse();
        chk("hold_mid", mode, 3);
        frame_pulse();
        chk("hold_done", mode, 0);
        chk("idle_rgb", rgb_out, 16'h001F);

        // lose and win together count as lose
        press(0);
        clear_counts();
        lose = 1; win = 1; cyc(); lose = 0; win = 0;
        chk("both_lives", lives, 2);
        chk("both_serve", serve_cnt, 1);
        chk("both_mode", mode, 1);

        // pause gates engine keys
        press(0);
        chk("pause_mode", mode, 2);
        chk("pause_en", game_en, 0);
        game_rgb = 16'hFFFF;
        clear_counts();
        press(2);
        chk("pause_flag2", flag_cnt[2], 1);
        chk("pause_gamekey", gk_cnt, 0);
`ifdef PAUSE_DIM_EN
        chk("pause_rgb", rgb_out, 16'h7BEF);
`else
        chk("pause_rgb", rgb_out, 16'hFFFF);
`endif
        press(0);
        chk("resume_mode", mode, 1);
        clear_counts();
        press(1);
        chk("play_gamekey", gk_cnt, 1);

        // win path, keys ignored in OVER
        win = 1; cyc(); win = 0;
        chk("win_mode", mode, 3);
        chk("win_won", won, 1);
        press(0);
        chk("over_key_ignored", mode, 3);
        frame_pulse();
        frame_pulse();
        chk("win_hold_done", mode, 0);

        // random phase
        for (int n = 0; n < 6000; n++) begin
            for (int k = 0; k < NK; k++)
                if ($urandom_range(0, 7) == 0) key_in[k] = ~key_in[k];
            lose       = ($urandom_range(0, 39) == 0);
            win        = ($urandom_range(0, 59) == 0);
            frame_tick = ($urandom_range(0, 5) == 0);
            start_rgb  = 16'($urandom);
            game_rgb   = 16'($urandom);
            over_rgb   = 16'($urandom);
            reset      = (n == 3000);
            cyc();
        end
        reset = 0; lose = 0; win = 0; frame_tick = 0;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
